serial_pattern_gen: RTL and testbench

Serial bit-pattern transmitter, the source side of the serial sequence-detector interface. It loads a PAT_W-bit pattern and a repeat count, then drives the pattern MSB-first, one bit per clock, on a single-bit serial line. The line connects directly to a detector's `in` port. Used as a stimulus source and on-chip pattern generator for the sequence-detector FSMs.

---
 rtl/serial_pattern_pkg.sv | 17 +
 rtl/serial_pattern_gen_shifter.sv | 34 +++
 rtl/serial_pattern_gen.sv | 68 ++++++
 tb/tb_serial_pattern_gen.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/serial_pattern_pkg.sv
// serial_pattern_pkg: shared state encodings and frame length; SERIAL_PATTERN_GEN_PARITY_EN adds a parity bit per frame
package serial_pattern_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_DONE   = 2'd3
  } state_t;
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  function automatic int frame_len(input int pat_w);
    return pat_w + PAR_BITS;
  endfunction
endpackage

// File: rtl/serial_pattern_gen_shifter.sv
// pattern_shifter: latched pattern and MSB-first bit index with wrap, exposing next-cycle bit for registered output
module pattern_shifter #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [PAT_W-1:0] pattern,
  output logic             nxt_bit,
  output logic             eof,
  output logic             par
);
  localparam int IW = $clog2(PAT_W);
  localparam logic [IW-1:0] TOP = IW'(PAT_W - 1);
  logic [PAT_W-1:0] pat_reg, pat_nxt;
  logic [IW-1:0] idx, idx_nxt;
  always_comb begin
    pat_nxt = load ? pattern : pat_reg;
    idx_nxt = load ? TOP : step ? (idx == '0 ? TOP : idx - 1'b1) : idx;
  end
  assign nxt_bit = pat_nxt[idx_nxt];
  assign eof = idx == '0;
  assign par = ^pat_reg;
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_reg <= '0;
      idx <= '0;
    end else begin
      pat_reg <= pat_nxt;
      idx <= idx_nxt;
    end
  end
endmodule

// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen: MSB-first serial pattern transmitter with repeat count and sticky stop; optional SERIAL_PATTERN_GEN_PARITY_EN
module serial_pattern_gen
  import serial_pattern_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic             stop,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);
  state_t state, nxt;
  logic [CNT_W-1:0] rem;
  logic stop_lat, nxt_bit, eof, par, frame_end, go_done, load, step, active;
  pattern_shifter #(.PAT_W(PAT_W)) u_shifter (
    .clk(clk), .rst(rst), .load(load), .step(step), .pattern(pattern),
    .nxt_bit(nxt_bit), .eof(eof), .par(par)
  );
  always_comb begin
    active = state == ST_SHIFT || state == ST_PARITY;
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
    frame_end = state == ST_PARITY;
`else
    frame_end = state == ST_SHIFT && eof;
`endif
    go_done = rem == CNT_W'(1) || stop_lat || stop;
    nxt = ST_IDLE;
    case (state)
      ST_IDLE:   nxt = start ? (repeat_cnt == '0 ? ST_DONE : ST_SHIFT) : ST_IDLE;
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
      ST_SHIFT:  nxt = eof ? ST_PARITY : ST_SHIFT;
      ST_PARITY: nxt = go_done ? ST_DONE : ST_SHIFT;
`else
      ST_SHIFT:  nxt = eof && go_done ? ST_DONE : ST_SHIFT;
`endif
      default:   nxt = ST_IDLE;
    endcase
    load = state == ST_IDLE && nxt == ST_SHIFT;
    step = state != ST_IDLE && nxt == ST_SHIFT;
  end
  // outputs are registered from the next state so they align with it
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      rem <= '0;
      stop_lat <= 1'b0;
      out <= 1'b0;
      out_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      rem <= load ? repeat_cnt : frame_end ? rem - 1'b1 : rem;
      stop_lat <= (frame_end || !active) ? 1'b0 : stop_lat | stop;
      out <= nxt == ST_SHIFT ? nxt_bit : nxt == ST_PARITY && par;
      out_valid <= nxt == ST_SHIFT || nxt == ST_PARITY;
      busy <= nxt != ST_IDLE;
      done <= nxt == ST_DONE;
    end
  end
endmodule

// File: tb/tb_serial_pattern_gen.sv
// tb_serial_pattern_gen: table-driven vectors with a bit scoreboard plus reset corner sequences
module tb_serial_pattern_gen;
  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
  localparam int FL = PAT_W + 1;
`else
  localparam int FL = PAT_W;
`endif
  typedef struct {
    logic [PAT_W-1:0] pat;
    logic [CNT_W-1:0] cnt;
    int stop_at;
    int frames;
    int hits;
  } vec_t;
  logic clk, rst, start, stop, out, out_valid, busy, done;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic sb[$];
  vec_t vecs[7];
  int passed = 0, total = 0;
  serial_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .repeat_cnt(repeat_cnt),
    .stop(stop), .out(out), .out_valid(out_valid), .busy(busy), .done(done)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic run_vec(input vec_t v);
    int nbits, k, hits;
    logic [3:0] h;
    logic b;
    bit seen;
    nbits = v.frames * FL;
    for (int i = 0; i < nbits; i++)
      sb.push_back(i % FL < PAT_W ? v.pat[PAT_W-1-(i % FL)] : ^v.pat);
    @(negedge clk);
    pattern = v.pat;
    repeat_cnt = v.cnt;
    start = 1'b1;
    k = 0;
    hits = 0;
    h = '0;
    seen = 0;
    for (int c = 1; c <= nbits + 8 && !seen; c++) begin
      @(negedge clk);
      start = 1'b0;
      stop = 1'b0;
      check("busy", busy, 1);
      if (out_valid) begin
        if (sb.size() == 0) check("extra_bit", out_valid, 0);
        else begin
          b = sb.pop_front();
          check("bit", out, b);
        end
        h = {h[2:0], out};
        if (k >= 3 && h == 4'b1010) hits++;
        if (k == v.stop_at) stop = 1'b1;
        if (k == 2) begin
          start = 1'b1;
          pattern = ~v.pat;
          repeat_cnt = 1;
        end
        k++;
      end
      if (done) begin
        seen = 1;
        check("done_cycle", c, 1 + nbits);
        check("valid_at_done", out_valid, 0);
      end
    end
    start = 1'b0;
    stop = 1'b0;
    check("done_seen", seen, 1);
    check("bits_left", sb.size(), 0);
    sb.delete();
`ifndef SERIAL_PATTERN_GEN_PARITY_EN
    if (v.hits >= 0) check("detector_hits", hits, v.hits);
`endif
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_valid", out_valid, 0);
  endtask
  initial begin
    vecs[0] = '{4'b1010, 8'd3, -1, 3, 5};
    vecs[1] = '{4'b0110, 8'd0, -1, 0, -1};
    vecs[2] = '{4'b1100, 8'd5, 5, 2, -1};
    vecs[3] = '{4'b1011, 8'd2, -1, 2, -1};
    vecs[4] = '{4'b0110, 8'd1, 3, 1, -1};
    vecs[5] = '{4'b1111, 8'd2, 0, 1, -1};
    vecs[6] = '{4'b1001, 8'd255, -1, 255, -1};
    rst = 1'b1;
    start = 1'b1;
    stop = 1'b0;
    pattern = 4'b1010;
    repeat_cnt = 3;
    repeat (2) begin
      @(negedge clk);
      check("rst_out", out, 0);
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
    end
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("post_rst_valid", out_valid, 0);
    check("post_rst_busy", busy, 0);
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);
    @(negedge clk);
    pattern = 4'b1010;
    repeat_cnt = 4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_valid_before_rst", out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out", out, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    repeat (FL * 4) begin
      @(negedge clk);
      check("midrst_no_done", done, 0);
      check("midrst_quiet", out_valid, 0);
    end
    run_vec(vecs[0]);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
